// File: rtl/key_repeat.sv
// Button event generator: press/release strobes plus auto-repeat after an
// initial delay, with enable gating and a saturating per-hold repeat counter.
module key_repeat #(
  parameter int unsigned INITIAL_DELAY = 500000,
  parameter int unsigned REPEAT_PERIOD = 250000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  input  logic       enable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       event_pulse,
  output logic       held,
  output logic [7:0] repeat_count
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(INITIAL_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             btn_prev;
  logic             press_n, release_n, repeat_n;
  logic [7:0]       count_n;
  logic             press_edge, release_edge;
  logic [7:0]       count_inc;

  assign press_edge   = btn_level & ~btn_prev;
  assign release_edge = ~btn_level & btn_prev;
  assign count_inc    = (repeat_count == 8'hFF) ? repeat_count : repeat_count + 8'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    repeat_n  = 1'b0;
    count_n   = repeat_count;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (press_edge) begin
            state_n = DELAY;
            count_n = '0;
            press_n = 1'b1;
          end
        end
        DELAY, REPEAT: begin
          // Release is checked before the terminal count so it wins a tie.
          if (!btn_level) begin
            state_n   = IDLE;
            cnt_n     = '0;
            release_n = release_edge;
          end else if (cnt == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
            state_n  = REPEAT;
            cnt_n    = '0;
            repeat_n = 1'b1;
            count_n  = count_inc;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_prev      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      event_pulse   <= 1'b0;
      held          <= 1'b0;
      repeat_count  <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_prev      <= btn_level;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      repeat_pulse  <= repeat_n;
      event_pulse   <= press_n | repeat_n;
      held          <= (state_n != IDLE);
      repeat_count  <= count_n;
    end
  end

endmodule
